additionneur_1bit_reg: RTL and testbench
========================================

// Module: additionneur_1bit_reg
// PURPOSE
//   1-bit full adder (s = a+b+rin, carry out rout), the leaf cell of the ripple and serial adders.
//   Combinational sum/carry outputs are always present.
//   Optional registered copies and a carry-feedback register support bit-serial addition,
//   LSB first, across clock cycles.
// PARAMETERS
//   REG_OUT    1'b1  1 = implement s_q/rout_q output registers; 0 = tie s_q/rout_q to 0
//   CARRY_INIT 1'b0  value loaded into carry_q on reset and on clear
// PORTS
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous reset, active-high
//   a       in   1  operand bit A
//   b       in   1  operand bit B
//   rin     in   1  carry-in (used when serial=0)
//   serial  in   1  1 = carry-in taken from carry_q instead of rin
//   en      in   1  clock enable for all registers
//   clear   in   1  synchronous: carry_q <= CARRY_INIT (start of a new serial word)
//   s       out  1  combinational sum bit
//   rout    out  1  combinational carry-out
//   s_q     out  1  registered sum
//   rout_q  out  1  registered carry-out
//   carry_q out  1  stored carry for serial mode
// BEHAVIOUR
//   - cin = serial ? carry_q : rin.
//   - s = a ^ b ^ cin; rout = (a&b) | (a&cin) | (b&cin).
//     Both are purely combinational, zero latency, no dependence on clk/en.
//   - With serial=0, s/rout depend only on a, b, rin, and are valid even during reset.
//   - Reset (rst=1, asynchronous): carry_q = CARRY_INIT; s_q = 0; rout_q = 0.
//     Registers hold these values while rst is high; s/rout are unaffected.
//   - On rising clk with en=1:
//     - s_q <= s; rout_q <= rout.
//     - carry_q <= clear ? CARRY_INIT : rout.
//   - en=0: all registers hold; clear is ignored.
//   - clear and serial together: carry_q reloads CARRY_INIT. The current-cycle s still uses
//     the old carry_q; drive clear one cycle before the LSB.
//   - Registered outputs have 1-cycle latency from the inputs.
//   - No overflow: the full result is {rout, s} (2 bits, max 3).
//   - Reset in mid-serial word aborts the word; carry_q restarts at CARRY_INIT.
//   - Outputs never X once inputs are known; no latches.
// TESTING
//   1 Comb, serial=0, 20 ns steps, {a,b,rin} = 000,100,110,111,101
//     -> {s,rout} = 00,10,01,11,01.
//   2 Exhaustive 8 combos of a,b,rin (serial=0) -> {rout,s} == a+b+rin arithmetically.
//   3 en=1, a=1,b=1,rin=0 for one clk -> next cycle s_q=0, rout_q=1; then en=0, change inputs
//     -> s_q/rout_q hold.
//   4 Serial 3+1 LSB first (clear, then a=1,1,0; b=1,0,0; serial=1)
//     -> s = 0,0,1 per cycle (sum 4); carry_q ends 0.
//   5 rst pulse asynchronously between clk edges with carry_q=1
//     -> carry_q, s_q, rout_q go 0 immediately; s/rout still track a,b,rin.
//   6 clear with en=0 -> carry_q unchanged; clear with en=1 -> carry_q=CARRY_INIT after the edge.

Source files
------------

// File: rtl/additionneur_1bit_reg.sv
// 1-bit full adder with combinational sum/carry, optional registered copies,
// and a carry-feedback register for LSB-first bit-serial addition.
module additionneur_1bit_reg #(
   parameter bit REG_OUT    = 1'b1,
   parameter bit CARRY_INIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic rin,
   input  logic serial,
   input  logic en,
   input  logic clear,
   output logic s,
   output logic rout,
   output logic s_q,
   output logic rout_q,
   output logic carry_q
);

   logic cin;
   logic carry_d;

   // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
   always_comb begin
      cin     = serial ? carry_q : rin;
      s       = a ^ b ^ cin;
      rout    = (a & b) | (a & cin) | (b & cin);
      carry_d = carry_q;
      if (en) begin
         carry_d = clear ? CARRY_INIT : rout;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= CARRY_INIT;
      end else begin
         carry_q <= carry_d;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         logic s_d;
         logic rout_d;

         always_comb begin
            s_d    = s_q;
            rout_d = rout_q;
            if (en) begin
               s_d    = s;
               rout_d = rout;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s_q    <= 1'b0;
               rout_q <= 1'b0;
            end else begin
               s_q    <= s_d;
               rout_q <= rout_d;
            end
         end
      end else begin : g_no_reg_out
         assign s_q    = 1'b0;
         assign rout_q = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_additionneur_1bit_reg.sv
// Self-checking bench for additionneur_1bit_reg: scoreboard queues hold the
// expected {rout,s} values, popped when the DUT output is sampled.
module tb_additionneur_1bit_reg;

   typedef struct packed {
      logic rout;
      logic s;
   } exp_t;

   logic clk = 1'b0;
   logic rst, a, b, rin, serial, en, clear;
   logic s, rout, s_q, rout_q, carry_q;

   int   total = 0;
   int   bad   = 0;
   exp_t comb_q[$];
   exp_t reg_q[$];
   logic carry_m;

   additionneur_1bit_reg #(.REG_OUT(1'b1), .CARRY_INIT(1'b0)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .rin(rin), .serial(serial),
      .en(en), .clear(clear), .s(s), .rout(rout), .s_q(s_q),
      .rout_q(rout_q), .carry_q(carry_q)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: {rout,s} is the 2-bit sum of three bits.
   function automatic exp_t add3(input logic x, input logic y, input logic z);
      logic [1:0] sum;
      sum = 2'(x) + 2'(y) + 2'(z);
      return exp_t'(sum);
   endfunction

   task automatic pop_comb(input string name);
      exp_t e;
      e = comb_q.pop_front();
      total++;
      if ({rout, s} !== e) begin
         bad++;
         $display("FAIL %s: got {rout,s}=%b%b expected %b%b", name, rout, s, e.rout, e.s);
      end
   endtask

   task automatic pop_reg(input string name);
      exp_t e;
      e = reg_q.pop_front();
      total++;
      if ({rout_q, s_q} !== e) begin
         bad++;
         $display("FAIL %s: got {rout_q,s_q}=%b%b expected %b%b", name, rout_q, s_q, e.rout, e.s);
      end
   endtask

   task automatic check_carry(input string name, input logic exp);
      total++;
      if (carry_q !== exp) begin
         bad++;
         $display("FAIL %s: got carry_q=%b expected %b", name, carry_q, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; a = 1'b1; b = 1'b1; rin = 1'b1;
      serial = 1'b0; en = 1'b1; clear = 1'b0;
      #2;
      check_carry("reset_carry", 1'b0);
      reg_q.push_back('{rout: 1'b0, s: 1'b0});
      pop_reg("reset_regs");
      comb_q.push_back(add3(1'b1, 1'b1, 1'b1));
      pop_comb("reset_comb_valid");
      @(posedge clk); #1;
      reg_q.push_back('{rout: 1'b0, s: 1'b0});
      pop_reg("reset_held");
      @(negedge clk);
      rst = 1'b0;
      carry_m = 1'b0;
   endtask

   task automatic test_comb_steps();
      logic [2:0] pat [5] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101};
      exp_t       res [5] = '{'{1'b0, 1'b0}, '{1'b0, 1'b1}, '{1'b1, 1'b0},
                              '{1'b1, 1'b1}, '{1'b1, 1'b0}};
      en = 1'b0; serial = 1'b0;
      for (int i = 0; i < 5; i++) begin
         {a, b, rin} = pat[i];
         comb_q.push_back(res[i]);
         #1;
         pop_comb($sformatf("comb_step_%0d", i));
         #19;
      end
   endtask

   task automatic test_exhaustive();
      logic [2:0] v;
      en = 1'b0; serial = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a, b, rin} = v;
         comb_q.push_back(add3(v[2], v[1], v[0]));
         #1;
         pop_comb($sformatf("exhaustive_%0d", i));
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      en = 1'b1; serial = 1'b0; clear = 1'b0;
      a = 1'b1; b = 1'b1; rin = 1'b0;
      reg_q.push_back('{rout: 1'b1, s: 1'b0});
      @(posedge clk); #1;
      pop_reg("reg_capture");
      carry_m = 1'b1;
      @(negedge clk);
      en = 1'b0; a = 1'b1; b = 1'b0; rin = 1'b0;
      reg_q.push_back('{rout: 1'b1, s: 1'b0});
      @(posedge clk); #1;
      pop_reg("reg_hold_en0");
      check_carry("carry_hold_en0", carry_m);
   endtask

   task automatic test_serial();
      logic av [3] = '{1'b1, 1'b1, 1'b0};
      logic bv [3] = '{1'b1, 1'b0, 1'b0};
      logic sv [3] = '{1'b0, 1'b0, 1'b1};
      @(negedge clk);
      en = 1'b1; clear = 1'b1; serial = 1'b0; a = 1'b0; b = 1'b0; rin = 1'b0;
      @(posedge clk); #1;
      check_carry("serial_clear", 1'b0);
      carry_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         clear = 1'b0; serial = 1'b1; a = av[i]; b = bv[i]; rin = 1'b0;
         comb_q.push_back(add3(av[i], bv[i], carry_m));
         #1;
         total++;
         if (s !== sv[i]) begin
            bad++;
            $display("FAIL serial_s_%0d: got s=%b expected %b", i, s, sv[i]);
         end
         pop_comb($sformatf("serial_comb_%0d", i));
         carry_m = add3(av[i], bv[i], carry_m).rout;
         @(posedge clk); #1;
      end
      check_carry("serial_final_carry", 1'b0);
      serial = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      en = 1'b1; clear = 1'b0; serial = 1'b0; a = 1'b1; b = 1'b1; rin = 1'b1;
      @(posedge clk); #1;
      check_carry("pre_rst_carry", 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_carry("async_rst_carry", 1'b0);
      reg_q.push_back('{rout: 1'b0, s: 1'b0});
      pop_reg("async_rst_regs");
      a = 1'b0; b = 1'b1; rin = 1'b0;
      comb_q.push_back(add3(1'b0, 1'b1, 1'b0));
      #1;
      pop_comb("rst_comb_tracks");
      @(negedge clk);
      rst = 1'b0;
      carry_m = 1'b0;
   endtask

   task automatic test_clear_en();
      @(negedge clk);
      en = 1'b1; clear = 1'b0; serial = 1'b0; a = 1'b1; b = 1'b1; rin = 1'b0;
      @(posedge clk); #1;
      check_carry("clr_setup", 1'b1);
      @(negedge clk);
      en = 1'b0; clear = 1'b1; a = 1'b0; b = 1'b0;
      @(posedge clk); #1;
      check_carry("clear_en0_ignored", 1'b1);
      @(negedge clk);
      en = 1'b1; clear = 1'b1; a = 1'b1; b = 1'b1;
      @(posedge clk); #1;
      check_carry("clear_en1", 1'b0);
      clear = 1'b0;
      carry_m = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t r;
      exp_t last_reg;
      last_reg = '{rout: rout_q, s: s_q};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         a = 1'($urandom); b = 1'($urandom); rin = 1'($urandom);
         serial = 1'($urandom); en = 1'($urandom); clear = ($urandom_range(0, 5) == 0);
         r = add3(a, b, serial ? carry_m : rin);
         comb_q.push_back(r);
         #1;
         pop_comb($sformatf("b2b_comb_%0d", i));
         if (en) begin
            last_reg = r;
            carry_m  = clear ? 1'b0 : r.rout;
         end
         reg_q.push_back(last_reg);
         @(posedge clk); #1;
         pop_reg($sformatf("b2b_reg_%0d", i));
         check_carry($sformatf("b2b_carry_%0d", i), carry_m);
      end
   endtask

   initial begin
      test_reset();
      test_comb_steps();
      test_exhaustive();
      test_registered();
      test_serial();
      test_async_reset();
      test_clear_en();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
